// File: rtl/mmh_job_sched_if.sv
// Requester and multiplier signal bundle for mmh_job_sched.
// The slave modport is the scheduler; master is the requester/multiplier side.
interface mmh_job_sched_if #(
  parameter int unsigned CW = 4
) ();
  logic            req0;
  logic [4*CW-1:0] opa0;
  logic [4*CW-1:0] opb0;
  logic            gnt0;
  logic            done0;
  logic            req1;
  logic [4*CW-1:0] opa1;
  logic [4*CW-1:0] opb1;
  logic            gnt1;
  logic            done1;
  logic [4*CW-1:0] mm_a;
  logic [4*CW-1:0] mm_b;
  logic            mm_stm;
  logic            mm_eom;
  logic [8*CW-1:0] mm_c;
  logic [8*CW-1:0] res;
  logic            busy;
  logic            err;

  modport master (
    output req0, opa0, opb0, req1, opa1, opb1, mm_eom, mm_c,
    input  gnt0, done0, gnt1, done1, mm_a, mm_b, mm_stm, res, busy, err
  );

  modport slave (
    input  req0, opa0, opb0, req1, opa1, opb1, mm_eom, mm_c,
    output gnt0, done0, gnt1, done1, mm_a, mm_b, mm_stm, res, busy, err
  );
endinterface

// File: rtl/mmh_job_sched.sv
// Round-robin job scheduler sharing one 2x2 hypercube matrix multiplier between two requesters.
// Define MMH_WDOG_EN to bound WAIT with a watchdog that raises the sticky ERR flag.
module mmh_job_sched #(
  parameter int unsigned CW       = 4,
  parameter int unsigned WD_LIMIT = 255
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  mmh_job_sched_if.slave bus_io
);
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StStart = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StCapt  = 3'd4;
  localparam logic [2:0] StResp  = 3'd5;

  logic [2:0]      state_q, state_d;
  logic            ptr_q;
  logic            sel_q;
  logic            sel_now;
  logic            any_req;
  logic            take;
  logic            timeout;
  logic [4*CW-1:0] mm_a_q;
  logic [4*CW-1:0] mm_b_q;
  logic [8*CW-1:0] res_q;

  assign any_req = bus_io.req0 | bus_io.req1;
  // Both requesting: the pointer decides; otherwise the lone requester wins.
  assign sel_now = (bus_io.req0 && bus_io.req1) ? ptr_q : bus_io.req1;
  assign take    = (state_q == StIdle) && any_req;

`ifdef MMH_WDOG_EN
  logic [7:0] wd_q;
  logic       err_q;

  assign timeout = (state_q == StWait) && !bus_io.mm_eom && (wd_q == 8'(WD_LIMIT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == StStart) begin
        wd_q <= '0;
      end else if (state_q == StWait) begin
        wd_q <= wd_q + 8'd1;
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus_io.err = err_q;
`else
  // WAIT is unbounded here; WD_LIMIT has no effect in this build.
  assign timeout    = 1'b0 && (WD_LIMIT > 0);
  assign bus_io.err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (any_req) state_d = StLoad;
      StLoad:  state_d = StStart;
      StStart: state_d = StWait;
      StWait: begin
        if (bus_io.mm_eom) begin
          state_d = StCapt;
        end else if (timeout) begin
          state_d = StResp;
        end
      end
      StCapt:  state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
      sel_q   <= 1'b0;
      mm_a_q  <= '0;
      mm_b_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        sel_q  <= sel_now;
        mm_a_q <= sel_now ? bus_io.opa1 : bus_io.opa0;
        mm_b_q <= sel_now ? bus_io.opb1 : bus_io.opb0;
      end
      if (state_q == StCapt) begin
        res_q <= bus_io.mm_c;
      end else if (timeout) begin
        res_q <= '0;
      end
      if (state_q == StResp) begin
        ptr_q <= ~sel_q;
      end
    end
  end

  // Grant is issued in the IDLE cycle itself; masked so it stays low while reset is held.
  assign bus_io.gnt0   = rst_ni && take && !sel_now;
  assign bus_io.gnt1   = rst_ni && take && sel_now;
  assign bus_io.done0  = (state_q == StResp) && !sel_q;
  assign bus_io.done1  = (state_q == StResp) && sel_q;
  assign bus_io.mm_stm = (state_q == StStart);
  assign bus_io.busy   = (state_q != StIdle);
  assign bus_io.mm_a   = mm_a_q;
  assign bus_io.mm_b   = mm_b_q;
  assign bus_io.res    = res_q;
endmodule
